axil_lite_responder: RTL and testbench

- Register-file responder for the 3-bit-address / 4-bit-data AXI-lite-style bus driven by the on-chip initiator; drop-in replacement for the existing responder at the other end of that link.
- Independent write (aw/w/b) and read (ar/r) channels, one outstanding transaction per channel, 8 x 4-bit storage.
- Side read port feeds the 7-segment display path in the top level.

---
 rtl/axil_lite_pkg.sv | 17 +
 rtl/axil_regfile.sv | 34 +++
 rtl/axil_lite_responder.sv | 136 +++++++++++++
 tb/tb_axil_lite_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_lite_pkg.sv
// Shared types and default widths for the 3-bit-address / 4-bit-data AXI-lite responder.
package axil_lite_pkg;
  localparam int AXIL_ADDR_W = 3;
  localparam int AXIL_DATA_W = 4;

  typedef enum logic [1:0] {
    WR_IDLE     = 2'd0,
    WR_GOT_ADDR = 2'd1,
    WR_GOT_DATA = 2'd2,
    WR_RESP     = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;
endpackage

// File: rtl/axil_regfile.sv
// 2**ADDR_W x DATA_W storage: one synchronous write port, two combinational read ports.
module axil_regfile
  import axil_lite_pkg::*;
#(
  parameter int                ADDR_W    = AXIL_ADDR_W,
  parameter int                DATA_W    = AXIL_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see pre-edge contents, so a same-edge write never leaks into a read.
  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/axil_lite_responder.sv
// AXI-lite-style register-file responder: independent write (aw/w/b) and read (ar/r)
// channels, one outstanding transaction each, plus a combinational debug read port.
module axil_lite_responder
  import axil_lite_pkg::*;
#(
  parameter int                ADDR_W    = AXIL_ADDR_W,
  parameter int                DATA_W    = AXIL_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              b_valid,
  input  logic              b_ready,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  wr_state_t         wr_state, wr_next;
  rd_state_t         rd_state, rd_next;
  logic              live;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ld_addr, ld_data;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_mem;
  logic              aw_hs, w_hs, ar_hs;

  // Holds all readies low through the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign aw_ready = live & ((wr_state == WR_IDLE) | (wr_state == WR_GOT_DATA));
  assign w_ready  = live & ((wr_state == WR_IDLE) | (wr_state == WR_GOT_ADDR));
  assign b_valid  = (wr_state == WR_RESP);
  assign ar_ready = live & (rd_state == RD_IDLE);
  assign r_valid  = (rd_state == RD_DATA);

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign ar_hs = ar_valid & ar_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      r_data   <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (ld_addr) addr_q <= aw_addr;
      if (ld_data) data_q <= w_data;
      if (ar_hs)   r_data <= rd_mem;
    end
  end

  always_comb begin
    wr_next = wr_state;
    ld_addr = 1'b0;
    ld_data = 1'b0;
    we      = 1'b0;
    waddr   = aw_addr;
    wdata   = w_data;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          we      = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) begin
          ld_addr = 1'b1;
          wr_next = WR_GOT_ADDR;
        end else if (w_hs) begin
          ld_data = 1'b1;
          wr_next = WR_GOT_DATA;
        end
      end
      WR_GOT_ADDR: begin
        waddr = addr_q;
        if (w_hs) begin
          we      = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_GOT_DATA: begin
        wdata = data_q;
        if (aw_hs) begin
          we      = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: if (b_ready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs)   rd_next = RD_DATA;
      RD_DATA: if (r_ready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  axil_regfile #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (ar_addr),
    .rdata    (rd_mem),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_axil_lite_responder.sv
// Directed bench for axil_lite_responder: vector table of write/read pairs plus
// hand-written sequences for reset, split writes, backpressure, collision and mid-op reset.
module tb_axil_lite_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic       ar_valid, ar_ready, r_valid, r_ready;
  logic [2:0] aw_addr, ar_addr, dbg_addr;
  logic [3:0] w_data, r_data, dbg_data;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [2:0] wa;
    logic [3:0] wd;
    logic [2:0] ra;
    logic [3:0] exp_rd;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  axil_lite_responder dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dbg(input string name, input logic [2:0] a, input logic [3:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  // Simultaneous aw/w write with b_ready high; expects b_valid exactly one cycle later.
  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    bit ok = 0;
    aw_valid = 1; aw_addr = a; w_valid = 1; w_data = d; b_ready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (aw_ready && w_ready) begin ok = 1; break; end
    end
    if (!ok) chk("wr_ready_timeout", 0, 1);
    chk("wr_bvalid_pre", b_valid, 0);
    step();
    aw_valid = 0; w_valid = 0;
    @(negedge clk);
    chk("wr_bvalid", b_valid, 1);
    chk_dbg("wr_dbg", a, d);
    step();
    b_ready = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [3:0] d);
    bit ok = 0;
    ar_valid = 1; ar_addr = a; r_ready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1; break; end
    end
    if (!ok) chk("rd_ready_timeout", 0, 1);
    chk("rd_rvalid_pre", r_valid, 0);
    step();
    ar_valid = 0;
    @(negedge clk);
    chk("rd_rvalid", r_valid, 1);
    d = r_data;
    step();
    r_ready = 0;
  endtask

  initial begin
    logic [3:0] got;
    vecs[0] = '{3'd5, 4'hA, 3'd5, 4'hA};
    vecs[1] = '{3'd0, 4'hF, 3'd0, 4'hF};
    vecs[2] = '{3'd7, 4'h1, 3'd7, 4'h1};
    vecs[3] = '{3'd3, 4'h6, 3'd5, 4'hA};
    vecs[4] = '{3'd5, 4'h4, 3'd5, 4'h4};
    vecs[5] = '{3'd1, 4'h9, 3'd3, 4'h6};

    rst_n = 0;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_addr = 0; ar_addr = 0; w_data = 0; dbg_addr = 0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_aw_ready_first", aw_ready, 0);
    chk("rst_w_ready_first", w_ready, 0);
    chk("rst_ar_ready_first", ar_ready, 0);
    step();
    @(negedge clk);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    for (int i = 0; i < 8; i++) chk_dbg("rst_dbg", 3'(i), 4'h0);

    // Table of write-then-read pairs
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].wa, vecs[i].wd);
      rd(vecs[i].ra, got);
      chk("vec_rdata", got, vecs[i].exp_rd);
    end

    // Split write: data first, address three cycles later
    step();
    w_valid = 1; w_data = 4'h3;
    @(negedge clk);
    chk("split_w_ready", w_ready, 1);
    step();
    w_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("split_wait_w_ready", w_ready, 0);
      chk("split_wait_aw_ready", aw_ready, 1);
      chk("split_wait_b_valid", b_valid, 0);
      if (k < 2) step();
    end
    step();
    aw_valid = 1; aw_addr = 3'd2; b_ready = 1;
    step();
    aw_valid = 0;
    @(negedge clk);
    chk("split_b_valid", b_valid, 1);
    chk_dbg("split_dbg2", 3'd2, 4'h3);
    step();
    b_ready = 0;
    @(negedge clk);
    chk("split_b_done", b_valid, 0);

    // Write response backpressure
    step();
    aw_valid = 1; aw_addr = 3'd4; w_valid = 1; w_data = 4'hC; b_ready = 0;
    step();
    aw_valid = 0; w_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_b_valid", b_valid, 1);
      chk("bp_aw_ready", aw_ready, 0);
      chk("bp_w_ready", w_ready, 0);
      step();
    end
    b_ready = 1;
    step();
    b_ready = 0;
    @(negedge clk);
    chk("bp_b_release", b_valid, 0);
    chk("bp_aw_ready_back", aw_ready, 1);

    // Read data backpressure
    step();
    ar_valid = 1; ar_addr = 3'd4; r_ready = 0;
    step();
    ar_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_r_valid", r_valid, 1);
      chk("bp_r_data", r_data, 4'hC);
      chk("bp_ar_ready", ar_ready, 0);
      step();
    end
    r_ready = 1;
    step();
    r_ready = 0;
    @(negedge clk);
    chk("bp_r_release", r_valid, 0);
    chk("bp_r_data_hold", r_data, 4'hC);

    // Read/write collision on addr 7 (currently 0x1)
    step();
    aw_valid = 1; aw_addr = 3'd7; w_valid = 1; w_data = 4'hF;
    ar_valid = 1; ar_addr = 3'd7; b_ready = 1; r_ready = 1;
    @(negedge clk);
    chk("col_all_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
    step();
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    @(negedge clk);
    chk("col_b_valid", b_valid, 1);
    chk("col_r_valid", r_valid, 1);
    chk("col_r_old", r_data, 4'h1);
    step();
    b_ready = 0; r_ready = 0;
    rd(3'd7, got);
    chk("col_r_new", got, 4'hF);

    // Reset in WR_GOT_ADDR and RD_DATA
    step();
    aw_valid = 1; aw_addr = 3'd3; ar_valid = 1; ar_addr = 3'd7; r_ready = 0; b_ready = 1;
    step();
    aw_valid = 0; ar_valid = 0;
    @(negedge clk);
    chk("mid_r_valid", r_valid, 1);
    chk("mid_w_ready", w_ready, 1);
    chk("mid_aw_ready", aw_ready, 0);
    #1 rst_n = 0;
    #1;
    chk("mid_r_valid_async", r_valid, 0);
    chk("mid_b_valid_async", b_valid, 0);
    chk("mid_w_ready_async", w_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    w_valid = 1; w_data = 4'h5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_b_valid", b_valid, 0);
      step();
      w_valid = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk_dbg("mid_dbg_reset", 3'(i), 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
